// File: rtl/fht_pkg.sv
// Shared constants for the FHT engine: transform geometry, pipeline latencies
// and the sequencer state codes.
package fht_pkg;

    localparam int N       = 256;
    localparam int A_BIT   = 8;
    localparam int D_BIT   = 17;
    localparam int W_BIT   = 16;

    localparam int RD_LAT  = 1;
    localparam int BUT_LAT = 2;
    localparam int WB_LAT  = RD_LAT + BUT_LAT;

    // Plain codes rather than an enum so older tools and probes can decode them
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_DRAIN = 3'd2;
    localparam logic [2:0] ST_SWAP  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Bits needed to hold a stage number 0..a_bit-1
    function automatic int s_width(input int a_bit);
        return (a_bit > 1) ? $clog2(a_bit) : 1;
    endfunction

endpackage

// File: rtl/fht_stage_seq_if.sv
// Bus between the stage sequencer and its data RAMs, twiddle ROM and butterfly.
// The master side is the sequencer; the slave side is the memory/butterfly fabric.
interface fht_stage_seq_if #(
    parameter int A_BIT = fht_pkg::A_BIT,
    parameter int D_BIT = fht_pkg::D_BIT
);
    logic [A_BIT-1:0] oRD_ADDR_0;
    logic [A_BIT-1:0] oRD_ADDR_1;
    logic [A_BIT-1:0] oRD_ADDR_2;
    logic [D_BIT-1:0] iRD_DATA_0;
    logic [D_BIT-1:0] iRD_DATA_1;
    logic [D_BIT-1:0] iRD_DATA_2;
    logic [A_BIT-2:0] oTW_ADDR;
    logic [D_BIT-1:0] oX_0;
    logic [D_BIT-1:0] oX_1;
    logic [D_BIT-1:0] oX_2;
    logic [D_BIT-1:0] iY_0;
    logic [D_BIT-1:0] iY_1;
    logic             oWR_EN;
    logic [A_BIT-1:0] oWR_ADDR_0;
    logic [A_BIT-1:0] oWR_ADDR_1;
    logic [D_BIT-1:0] oWR_DATA_0;
    logic [D_BIT-1:0] oWR_DATA_1;

    modport master (
        output oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oTW_ADDR,
        output oX_0, oX_1, oX_2,
        output oWR_EN, oWR_ADDR_0, oWR_ADDR_1, oWR_DATA_0, oWR_DATA_1,
        input  iRD_DATA_0, iRD_DATA_1, iRD_DATA_2, iY_0, iY_1
    );

    modport slave (
        input  oRD_ADDR_0, oRD_ADDR_1, oRD_ADDR_2, oTW_ADDR,
        input  oX_0, oX_1, oX_2,
        input  oWR_EN, oWR_ADDR_0, oWR_ADDR_1, oWR_DATA_0, oWR_DATA_1,
        output iRD_DATA_0, iRD_DATA_1, iRD_DATA_2, iY_0, iY_1
    );

endinterface

// File: rtl/fht_addr_gen.sv
// Combinational (stage, butterfly index) -> three read addresses and twiddle index
// for a radix-2 FHT stage. Shared with the bit-reversal loader.
module fht_addr_gen #(
    parameter int A_BIT = fht_pkg::A_BIT,
    parameter int S_BIT = fht_pkg::s_width(fht_pkg::A_BIT)
) (
    input  logic [S_BIT-1:0] s,
    input  logic [A_BIT-2:0] j,
    output logic [A_BIT-1:0] addr_0,
    output logic [A_BIT-1:0] addr_1,
    output logic [A_BIT-1:0] addr_2,
    output logic [A_BIT-2:0] tw_addr
);
    import fht_pkg::*;

    localparam logic [A_BIT-1:0] ONE   = A_BIT'(1);
    localparam logic [S_BIT-1:0] S_TOP = S_BIT'(A_BIT - 1);

    logic [A_BIT-2:0] low_mask;
    logic [A_BIT-2:0] k;
    logic [A_BIT-1:0] k_ext;
    logic [A_BIT-1:0] g;
    logic [A_BIT-1:0] h;
    logic [S_BIT-1:0] tw_shift;

    // k is j mod h and g is the block base 2h*(j/h); both fall out of masking j
    // because h is a power of two. Wrap of g+2h at the last stage is intentional.
    always_comb begin
        low_mask = ~({(A_BIT-1){1'b1}} << s);
        k        = j & low_mask;
        k_ext    = {1'b0, k};
        g        = {j & ~low_mask, 1'b0};
        h        = ONE << s;
        tw_shift = S_TOP - s;

        addr_0   = g + k_ext;
        addr_1   = g + h + k_ext;
        addr_2   = (k == '0) ? (g + h) : (g + (h << 1) - k_ext);
        tw_addr  = k << tw_shift;
    end

endmodule

// File: rtl/fht_stage_seq.sv
// Stage sequencer for a single-butterfly FHT: walks all log2(N) stages over a
// ping-pong RAM pair, aligns operands to the butterfly and writes results back.
module fht_stage_seq #(
    parameter int N     = fht_pkg::N,
    parameter int A_BIT = fht_pkg::A_BIT,
    parameter int D_BIT = fht_pkg::D_BIT
) (
    input  logic iCLK,
    input  logic iRESET,
    input  logic iSTART,
    output logic oBUSY,
    output logic oDONE,
    output logic oBANK,
    fht_stage_seq_if.master bus
);
    import fht_pkg::*;

    localparam int               S_BIT  = s_width(A_BIT);
    localparam logic [A_BIT-2:0] J_LAST = (A_BIT-1)'(N/2 - 1);
    localparam logic [A_BIT-2:0] J_ONE  = (A_BIT-1)'(1);
    localparam logic [S_BIT-1:0] S_LAST = S_BIT'(A_BIT - 1);
    localparam logic [S_BIT-1:0] S_ONE  = S_BIT'(1);
    localparam logic [1:0]       D_LAST = 2'(WB_LAT - 1);

    logic [2:0]       state;
    logic [S_BIT-1:0] s;
    logic [A_BIT-2:0] j;
    logic [1:0]       drain_cnt;
    logic             bank;
    logic             done_q;
    logic             issue;

    logic [A_BIT-1:0] addr_0;
    logic [A_BIT-1:0] addr_1;
    logic [A_BIT-1:0] addr_2;
    logic [A_BIT-2:0] tw_addr;

    logic [WB_LAT-1:0] vld;
    logic [A_BIT-1:0]  a0_dl [WB_LAT];
    logic [A_BIT-1:0]  a1_dl [WB_LAT];
    logic [D_BIT-1:0]  x0_q;

    fht_addr_gen #(
        .A_BIT (A_BIT),
        .S_BIT (S_BIT)
    ) u_addr_gen (
        .s       (s),
        .j       (j),
        .addr_0  (addr_0),
        .addr_1  (addr_1),
        .addr_2  (addr_2),
        .tw_addr (tw_addr)
    );

    assign issue = (state == ST_RUN);

    // Stage walk: one butterfly per RUN cycle, DRAIN lets the write-back pipe
    // empty before SWAP flips banks, so the next stage never reads stale words.
    // The bank is re-zeroed at start so results always land in bank A_BIT mod 2.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state     <= ST_IDLE;
            s         <= '0;
            j         <= '0;
            drain_cnt <= '0;
            bank      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (iSTART) begin
                        state <= ST_RUN;
                        s     <= '0;
                        j     <= '0;
                        bank  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (j == J_LAST) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        j <= j + J_ONE;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == D_LAST) begin
                        state <= ST_SWAP;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                ST_SWAP: begin
                    bank <= ~bank;
                    if (s == S_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        s     <= s + S_ONE;
                        j     <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Write-back pipe: valid and addresses ride alongside the RAM read and the
    // butterfly; never flushed between stages, the valid bits simply drain out.
    // X0 is held one extra cycle because the butterfly adds it after the multiply.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            vld  <= '0;
            x0_q <= '0;
            for (int i = 0; i < WB_LAT; i++) begin
                a0_dl[i] <= '0;
                a1_dl[i] <= '0;
            end
        end else begin
            vld      <= {vld[WB_LAT-2:0], issue};
            x0_q     <= bus.iRD_DATA_0;
            a0_dl[0] <= addr_0;
            a1_dl[0] <= addr_1;
            for (int i = 1; i < WB_LAT; i++) begin
                a0_dl[i] <= a0_dl[i-1];
                a1_dl[i] <= a1_dl[i-1];
            end
        end
    end

    assign oBUSY          = (state == ST_RUN) || (state == ST_DRAIN) || (state == ST_SWAP);
    assign oDONE          = done_q;
    assign oBANK          = bank;

    assign bus.oRD_ADDR_0 = addr_0;
    assign bus.oRD_ADDR_1 = addr_1;
    assign bus.oRD_ADDR_2 = addr_2;
    assign bus.oTW_ADDR   = tw_addr;

    assign bus.oX_0       = x0_q;
    assign bus.oX_1       = bus.iRD_DATA_1;
    assign bus.oX_2       = bus.iRD_DATA_2;

    assign bus.oWR_EN     = vld[WB_LAT-1];
    assign bus.oWR_ADDR_0 = a0_dl[WB_LAT-1];
    assign bus.oWR_ADDR_1 = a1_dl[WB_LAT-1];
    assign bus.oWR_DATA_0 = bus.iY_0;
    assign bus.oWR_DATA_1 = bus.iY_1;

endmodule

// File: tb/tb_fht_stage_seq.sv
// Bench for fht_stage_seq at N=8 with behavioural ping-pong RAMs and a 2-cycle
// stub butterfly; a per-cycle checker compares the DUT against a schedule model.
module tb_fht_stage_seq;

    localparam int N     = 8;
    localparam int A     = 3;
    localparam int D     = 17;
    localparam int P     = N/2 + 4;
    localparam int TOTAL = A * P;
    localparam int MASK  = (1 << D) - 1;

    logic iCLK = 1'b0;
    logic iRESET;
    logic iSTART;
    logic oBUSY;
    logic oDONE;
    logic oBANK;

    fht_stage_seq_if #(.A_BIT(A), .D_BIT(D)) bus ();

    fht_stage_seq #(
        .N     (N),
        .A_BIT (A),
        .D_BIT (D)
    ) dut (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .iSTART (iSTART),
        .oBUSY  (oBUSY),
        .oDONE  (oDONE),
        .oBANK  (oBANK),
        .bus    (bus)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int busy_cnt = 0;

    int init_data [N];
    int load_seq = 0;
    int seen_seq = 0;
    int stg [A+1][N];
    logic [D-1:0] mem [2][N];
    logic [D-1:0] p1;
    logic [D-1:0] p2;

    bit active = 1'b0;
    int n = 0;

    task automatic check_output(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference butterfly placement in block/offset terms
    task automatic bfly(input int st, input int jj, output int a0, output int a1,
                        output int a2, output int t);
        int h;
        int b;
        int k;
        int base;
        h    = 1 << st;
        b    = jj / h;
        k    = jj % h;
        base = b * 2 * h;
        a0   = base + k;
        a1   = base + h + k;
        a2   = base + h + ((h - k) % h);
        t    = k * (N / (2 * h));
    endtask

    function automatic int f0(input int x0, input int x1);
        return (x0 + x1) & MASK;
    endfunction

    function automatic int f1(input int x0, input int x1, input int x2);
        return (x0 - x1 + x2) & MASK;
    endfunction

    function automatic bit is_run(input int m);
        return (m >= 0) && (m < TOTAL) && ((m % P) < N/2);
    endfunction

    always @(posedge iCLK) cyc++;

    // Ping-pong RAM pair: reads from bank oBANK, writes to the other bank
    always @(posedge iCLK) begin
        if (load_seq != seen_seq) begin
            for (int i = 0; i < N; i++) mem[0][i] = D'(init_data[i]);
            seen_seq = load_seq;
        end
        if (bus.oWR_EN) begin
            mem[~oBANK][bus.oWR_ADDR_0] = bus.oWR_DATA_0;
            mem[~oBANK][bus.oWR_ADDR_1] = bus.oWR_DATA_1;
        end
        bus.iRD_DATA_0 <= mem[oBANK][bus.oRD_ADDR_0];
        bus.iRD_DATA_1 <= mem[oBANK][bus.oRD_ADDR_1];
        bus.iRD_DATA_2 <= mem[oBANK][bus.oRD_ADDR_2];
    end

    // Stub butterfly: X1/X2 captured one cycle before X0 arrives, Y two cycles later
    always @(posedge iCLK) begin
        p1        <= bus.oX_1;
        p2        <= bus.oX_2;
        bus.iY_0  <= bus.oX_0 + p1;
        bus.iY_1  <= bus.oX_0 - p1 + p2;
    end

    // Schedule model: n counts cycles since the accepted start edge
    always @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            active = 1'b0;
            n      = 0;
        end else if ((!active || n >= TOTAL + 1) && iSTART) begin
            active = 1'b1;
            n      = 0;
        end else if (active) begin
            n++;
        end
    end

    // Per-cycle compare of every meaningful DUT output against the model
    always @(negedge iCLK) begin
        int a0, a1, a2, t, st;
        bit exp_wr;
        check_output("busy", oBUSY, active && (n < TOTAL));
        check_output("done", oDONE, active && (n == TOTAL + 1));
        check_output("bank", oBANK, !active ? 0 : ((n < TOTAL) ? (n / P) % 2 : A % 2));
        if (active && n == 0) busy_cnt = 0;
        if (oBUSY) busy_cnt++;
        if (active && is_run(n)) begin
            bfly(n / P, n % P, a0, a1, a2, t);
            check_output("rd_addr_0", bus.oRD_ADDR_0, a0);
            check_output("rd_addr_1", bus.oRD_ADDR_1, a1);
            check_output("rd_addr_2", bus.oRD_ADDR_2, a2);
            check_output("tw_addr", bus.oTW_ADDR, t);
        end
        if (active && is_run(n - 1)) begin
            st = (n - 1) / P;
            bfly(st, (n - 1) % P, a0, a1, a2, t);
            check_output("x_1", bus.oX_1, stg[st][a1]);
            check_output("x_2", bus.oX_2, stg[st][a2]);
        end
        if (active && is_run(n - 2)) begin
            st = (n - 2) / P;
            bfly(st, (n - 2) % P, a0, a1, a2, t);
            check_output("x_0", bus.oX_0, stg[st][a0]);
        end
        exp_wr = active && is_run(n - 3);
        check_output("wr_en", bus.oWR_EN, exp_wr);
        if (exp_wr) begin
            st = (n - 3) / P;
            bfly(st, (n - 3) % P, a0, a1, a2, t);
            check_output("wr_addr_0", bus.oWR_ADDR_0, a0);
            check_output("wr_addr_1", bus.oWR_ADDR_1, a1);
            check_output("wr_data_0", bus.oWR_DATA_0, f0(stg[st][a0], stg[st][a1]));
            check_output("wr_data_1", bus.oWR_DATA_1,
                         f1(stg[st][a0], stg[st][a1], stg[st][a2]));
        end
    end

    // Preload bank 0 with random data, build the expected stage images, pulse start.
    // Entered just after a rising edge; returns just after the start-sample edge.
    task automatic apply_stimulus(input int repulse_at);
        int a0, a1, a2, t;
        for (int i = 0; i < N; i++) begin
            init_data[i] = int'($urandom) & MASK;
            stg[0][i]    = init_data[i];
        end
        for (int st = 0; st < A; st++) begin
            for (int jj = 0; jj < N/2; jj++) begin
                bfly(st, jj, a0, a1, a2, t);
                stg[st+1][a0] = f0(stg[st][a0], stg[st][a1]);
                stg[st+1][a1] = f1(stg[st][a0], stg[st][a1], stg[st][a2]);
            end
        end
        load_seq++;
        iSTART = 1'b1;
        @(posedge iCLK);
        #1;
        iSTART    = 1'b0;
        start_cyc = cyc;
        if (repulse_at > 0) begin
            repeat (repulse_at) @(posedge iCLK);
            #1 iSTART = 1'b1;
            @(posedge iCLK);
            #1 iSTART = 1'b0;
        end
    endtask

    // Wait (bounded) for oDONE, then check latency, busy length and the result bank
    task automatic finish_transform(input string tag);
        bit seen;
        int lat;
        seen = 1'b0;
        lat  = -1;
        while (!seen && (cyc - start_cyc) <= 4 * TOTAL) begin
            @(negedge iCLK);
            if (oDONE) begin
                seen = 1'b1;
                lat  = cyc - start_cyc;
            end
        end
        check_output({tag, "_done_seen"}, seen, 1);
        // N=8: three stages of 8 cycles, done pulse one cycle after the DONE state
        check_output({tag, "_done_latency"}, lat, 25);
        check_output({tag, "_busy_cycles"}, busy_cnt, 24);
        for (int i = 0; i < N; i++) begin
            check_output({tag, "_result"}, mem[A % 2][i], stg[A][i]);
        end
    endtask

    initial begin
        int a0, a1, a2, t;
        iRESET = 1'b1;
        iSTART = 1'b0;
        #2 iRESET = 1'b0;
        repeat (3) @(posedge iCLK);
        #1 iRESET = 1'b1;

        @(negedge iCLK);
        check_output("reset_busy", oBUSY, 0);
        check_output("reset_bank", oBANK, 0);
        check_output("reset_done", oDONE, 0);
        check_output("reset_wr_en", bus.oWR_EN, 0);

        // Hand-derived N=8 placements pin the reference model
        bfly(2, 1, a0, a1, a2, t);
        check_output("pin_s2j1_a0", a0, 1);
        check_output("pin_s2j1_a1", a1, 5);
        check_output("pin_s2j1_a2", a2, 7);
        check_output("pin_s2j1_t", t, 1);
        bfly(2, 3, a0, a1, a2, t);
        check_output("pin_s2j3_a2", a2, 5);
        check_output("pin_s2j3_t", t, 3);
        bfly(1, 3, a0, a1, a2, t);
        check_output("pin_s1j3_a0", a0, 5);
        check_output("pin_s1j3_a2", a2, 7);
        check_output("pin_s1j3_t", t, 2);
        bfly(0, 2, a0, a1, a2, t);
        check_output("pin_s0j2_a1", a1, 5);
        check_output("pin_s0j2_a2", a2, 5);
        check_output("pin_f1", f1(3, 5, 1), MASK);

        // First transform with a stray start pulse mid-run
        @(posedge iCLK);
        #1;
        apply_stimulus(5);
        finish_transform("first");

        // Back-to-back: start in the cycle right after the done pulse
        @(posedge iCLK);
        #1;
        apply_stimulus(0);
        finish_transform("b2b");

        // Abort at stage 1, j=2
        @(posedge iCLK);
        #1;
        apply_stimulus(0);
        repeat (P + 2) @(posedge iCLK);
        #1 iRESET = 1'b0;
        @(negedge iCLK);
        check_output("abort_wr_en", bus.oWR_EN, 0);
        check_output("abort_busy", oBUSY, 0);
        check_output("abort_bank", oBANK, 0);
        @(posedge iCLK);
        #1 iRESET = 1'b1;
        apply_stimulus(0);
        finish_transform("after_abort");

        // Random idle gaps and stray start pulses
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, 4)) @(posedge iCLK);
            @(posedge iCLK);
            #1;
            apply_stimulus(int'($urandom_range(0, 18)));
            finish_transform("random");
        end

        repeat (4) @(negedge iCLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
